// File: rtl/tick_scheduler.sv
// Per-channel clock-enable generator: one-cycle tick pulses at programmable
// divisors, with global start/stop and a one-cycle phase-align state.
module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int CH_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic              running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALIGN = 2'd2
  } state_t;

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_q [NUM_CH];
  logic [NUM_CH-1:0]  tick_q;
  logic               cfg_err_q;
  logic               wr_acc;
  logic               ch_ok;
  logic               counting;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // stop dominates; sync only matters in RUN, start only in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop)      state_d = IDLE;
        else if (sync) state_d = ALIGN;
      end
      ALIGN:   state_d = stop ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready = (state_q != ALIGN);
  assign wr_acc    = cfg_valid && cfg_ready;
  assign ch_ok     = ({1'b0, cfg_ch} < NUM_CH_L);
  // Counters advance only on edges that stay in RUN; entering RUN leaves
  // them at 0 so the first tick lands div cycles after the entry edge.
  assign counting  = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= wr_acc && !ch_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_acc && ch_ok && (cfg_ch == CH_W'(i))) begin
          div_q[i]  <= cfg_div;
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b0;
        end else if (!counting || (div_q[i] == '0)) begin
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b0;
        end else if (cnt_q[i] == (div_q[i] - DIV_W'(1))) begin
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b1;
        end else begin
          cnt_q[i]  <= cnt_q[i] + DIV_W'(1);
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;
  assign running = (state_q != IDLE);

endmodule
